hbc_io_phy: RTL and testbench

- Parametrised, clocked HyperBus pad-interface successor to the plain tri-state IO wrapper.
- Adds a configurable DQ width and registered output/enable paths.
- Adds an enforced bus-turnaround state machine and RWDS-qualified oversampled read capture into a small ready/valid FIFO.
- Sits between the HyperBus controller FSM and the physical DQ/RWDS pads.

---
 rtl/hbc_pkg.sv | 29 ++
 rtl/hbc_io_pad.sv | 29 ++
 rtl/hbc_io_phy.sv | 242 ++++++++++++++++++++++++
 tb/tb_hbc_io_phy.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hbc_pkg.sv
// Shared definitions for the HyperBus pad interface.
//   bus_state_t  : direction state of the pad interface (2-bit encoding is
//                  visible on the bus_state port of hbc_io_phy).
//   DQ_W_DEFAULT : default DQ width.
//   clog2        : constant-evaluable ceiling log2 used for pointer/counter widths.
package hbc_pkg;

    typedef enum logic [1:0] {
        BUS_RX      = 2'd0,
        BUS_TURN_TX = 2'd1,
        BUS_TX      = 2'd2,
        BUS_TURN_RX = 2'd3
    } bus_state_t;

    localparam int DQ_W_DEFAULT = 8;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(8) = 3.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hbc_io_pad.sv
// Tri-state pad cells for the HyperBus DQ bus and RWDS strobe.
// Purely structural: all output and enable registers live in hbc_io_phy.
//   dq_o / dq_de     : DQ output value and common output enable
//   rwds_o / rwds_de : RWDS output value and output enable
//   dq_i / rwds_i    : raw (unsynchronised) pad input values
//   DQ / RWDS        : bidirectional pads
module hbc_io_pad #(
    parameter int DQ_W = 8
) (
    input  logic [DQ_W-1:0] dq_o,
    input  logic            dq_de,
    input  logic            rwds_o,
    input  logic            rwds_de,
    output logic [DQ_W-1:0] dq_i,
    output logic            rwds_i,
    inout  wire  [DQ_W-1:0] DQ,
    inout  wire             RWDS
);

    // One tri-state cell per DQ bit.
    for (genvar i = 0; i < DQ_W; i++) begin : g_dq_pad
        assign DQ[i] = dq_de ? dq_o[i] : 1'bz;
    end

    assign RWDS   = rwds_de ? rwds_o : 1'bz;
    assign dq_i   = DQ;
    assign rwds_i = RWDS;

endmodule

// File: rtl/hbc_io_phy.sv
// HyperBus pad interface: registered TX drive path, enforced bus turnaround,
// and RWDS-qualified oversampled read capture into a first-word-fall-through FIFO.
//   clk, rst              : clock, synchronous active-high reset
//   drv_req               : 1 = controller wants to drive, 0 = receive
//   tx_valid/tx_ready     : write beat handshake; tx_data/tx_rwds are the beat
//   tx_rwds_oe            : drive RWDS while transmitting
//   rx_en                 : enable read capture while receiving
//   rx_valid/rx_ready     : read FIFO handshake; rx_data is the FIFO head
//   ovf / ovf_clr         : sticky overflow flag and its clear
//   bus_state             : 0=RX, 1=TURN_TX, 2=TX, 3=TURN_RX
//   RWDS, DQ              : pads
module hbc_io_phy
    import hbc_pkg::*;
#(
    parameter int DQ_W        = DQ_W_DEFAULT,
    parameter int TURN_CYC    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            drv_req,
    input  logic            tx_valid,
    output logic            tx_ready,
    input  logic [DQ_W-1:0] tx_data,
    input  logic            tx_rwds,
    input  logic            tx_rwds_oe,
    input  logic            rx_en,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic [DQ_W-1:0] rx_data,
    output logic            ovf,
    input  logic            ovf_clr,
    output logic [1:0]      bus_state,
    inout  wire             RWDS,
    inout  wire  [DQ_W-1:0] DQ
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int CW = clog2(TURN_CYC) + 1;
    localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYC - 1);

    bus_state_t      state;
    bus_state_t      next_state;
    logic [CW-1:0]   turn_cnt;

    logic            dq_de_next;
    logic            rwds_de_next;
    logic            dq_de;
    logic            rwds_de;
    logic [DQ_W-1:0] dq_o;
    logic            rwds_o;
    logic [DQ_W-1:0] dq_i;
    logic            rwds_i;

    logic [SYNC_STAGES-1:0] rwds_sync;
    logic [DQ_W-1:0]        dq_sync [SYNC_STAGES];
    logic                   rwds_dly;
    logic                   rwds_s;
    logic [DQ_W-1:0]        dq_s;
    logic                   push;
    logic [DQ_W-1:0]        push_data;

    logic [DQ_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            fifo_empty;
    logic            fifo_full;
    logic            do_pop;
    logic            do_push;
    logic            ovf_set;

    hbc_io_pad #(.DQ_W(DQ_W)) u_pad (
        .dq_o    (dq_o),
        .dq_de   (dq_de),
        .rwds_o  (rwds_o),
        .rwds_de (rwds_de),
        .dq_i    (dq_i),
        .rwds_i  (rwds_i),
        .DQ      (DQ),
        .RWDS    (RWDS)
    );

    // Direction state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BUS_RX;
        end else begin
            state <= next_state;
        end
    end

    // Turnaround counter: loaded on entry to a TURN state, counts down to 0 while there.
    always_ff @(posedge clk) begin
        if (rst) begin
            turn_cnt <= '0;
        end else if (((next_state == BUS_TURN_TX) || (next_state == BUS_TURN_RX))
                     && (next_state != state)) begin
            turn_cnt <= TURN_LOAD;
        end else if (((state == BUS_TURN_TX) || (state == BUS_TURN_RX))
                     && (turn_cnt != '0)) begin
            turn_cnt <= turn_cnt - 1'b1;
        end else begin
            turn_cnt <= turn_cnt;
        end
    end

    // Next-state logic; at the end of a turnaround the destination follows the
    // current drv_req so a request flip during the gap is honoured.
    always_comb begin
        next_state = state;
        case (state)
            BUS_RX: begin
                if (drv_req) next_state = BUS_TURN_TX;
                else         next_state = BUS_RX;
            end
            BUS_TURN_TX, BUS_TURN_RX: begin
                if (turn_cnt == '0) next_state = drv_req ? BUS_TX : BUS_RX;
                else                next_state = state;
            end
            BUS_TX: begin
                if (!drv_req) next_state = BUS_TURN_RX;
                else          next_state = BUS_TX;
            end
            default: next_state = BUS_RX;
        endcase
    end

    // Output decode; enables are computed from next_state so the registered
    // enables coincide exactly with state == TX.
    always_comb begin
        tx_ready     = (state == BUS_TX);
        dq_de_next   = (next_state == BUS_TX);
        rwds_de_next = dq_de_next & tx_rwds_oe;
    end

    // Registered pad enables and output data.
    always_ff @(posedge clk) begin
        if (rst) begin
            dq_de   <= 1'b0;
            rwds_de <= 1'b0;
            dq_o    <= '0;
            rwds_o  <= 1'b0;
        end else begin
            dq_de   <= dq_de_next;
            rwds_de <= rwds_de_next;
            if (tx_valid && tx_ready) begin
                dq_o   <= tx_data;
                rwds_o <= tx_rwds;
            end else begin
                dq_o   <= dq_o;
                rwds_o <= rwds_o;
            end
        end
    end

    assign rwds_s = rwds_sync[SYNC_STAGES-1];
    assign dq_s   = dq_sync[SYNC_STAGES-1];

    // Input synchronisers; RWDS and DQ have equal depth so data stays aligned with its edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rwds_sync <= '0;
            rwds_dly  <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                dq_sync[i] <= '0;
            end
        end else begin
            rwds_sync <= {rwds_sync[SYNC_STAGES-2:0], rwds_i};
            rwds_dly  <= rwds_s;
            dq_sync[0] <= dq_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dq_sync[i] <= dq_sync[i-1];
            end
        end
    end

    // Capture request: one push per RWDS edge (either polarity) while receiving.
    always_ff @(posedge clk) begin
        if (rst) begin
            push      <= 1'b0;
            push_data <= '0;
        end else begin
            push      <= (rwds_s ^ rwds_dly) & (state == BUS_RX) & rx_en;
            push_data <= dq_s;
        end
    end

    // FIFO control: a pop on an empty FIFO is ignored; a pop frees the slot for
    // a simultaneous push when full.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_pop     = rx_ready & ~fifo_empty;
        do_push    = push & (~fifo_full | do_pop);
        ovf_set    = push & fifo_full & ~do_pop;
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // FIFO pointers with wrap bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop  ? rd_ptr + 1'b1 : rd_ptr;
        end
    end

    // Sticky overflow; a clear in the same cycle as an overflow wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else begin
            ovf <= ovf;
        end
    end

    // First-word-fall-through head; reads as zero when empty.
    always_comb begin
        rx_valid = ~fifo_empty;
        if (fifo_empty) begin
            rx_data = '0;
        end else begin
            rx_data = mem[rd_ptr[AW-1:0]];
        end
    end

    assign bus_state = state;

endmodule

// File: tb/tb_hbc_io_phy.sv
// Self-checking bench for hbc_io_phy: table-driven direction/TX sequence,
// hand-written FIFO corner sequences, a randomized RX run checked against a
// queue model, and a 16-bit instance for the wide-bus case.
module tb_hbc_io_phy;

    logic        clk;
    logic        rst;
    logic        rst16;
    logic        drv_req;
    logic        tx_valid;
    logic        tx_rwds;
    logic        tx_rwds_oe;
    logic        rx_en;
    logic        rx_ready;
    logic        ovf_clr;
    logic [7:0]  tx_data;
    logic [15:0] tx_data16;

    logic        tx_ready, rx_valid, ovf;
    logic [7:0]  rx_data;
    logic [1:0]  bus_state;
    wire         RWDS8;
    wire  [7:0]  DQ8;

    logic        tx_ready16, rx_valid16, ovf16;
    logic [15:0] rx_data16;
    logic [1:0]  bus_state16;
    wire         RWDS16;
    wire  [15:0] DQ16;

    logic        tb_en;
    logic        tb_rwds;
    logic [7:0]  tb_dq;

    int n_tests;
    int n_fail;

    assign DQ8   = tb_en ? tb_dq : 8'hzz;
    assign RWDS8 = tb_en ? tb_rwds : 1'bz;

    hbc_io_phy #(.DQ_W(8), .TURN_CYC(2), .SYNC_STAGES(2), .FIFO_DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .drv_req(drv_req), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_rwds(tx_rwds), .tx_rwds_oe(tx_rwds_oe), .rx_en(rx_en),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .ovf(ovf),
        .ovf_clr(ovf_clr), .bus_state(bus_state), .RWDS(RWDS8), .DQ(DQ8)
    );

    hbc_io_phy #(.DQ_W(16), .TURN_CYC(2), .SYNC_STAGES(2), .FIFO_DEPTH(8)) dut16 (
        .clk(clk), .rst(rst16), .drv_req(drv_req), .tx_valid(tx_valid), .tx_ready(tx_ready16),
        .tx_data(tx_data16), .tx_rwds(tx_rwds), .tx_rwds_oe(tx_rwds_oe), .rx_en(rx_en),
        .rx_valid(rx_valid16), .rx_ready(rx_ready), .rx_data(rx_data16), .ovf(ovf16),
        .ovf_clr(ovf_clr), .bus_state(bus_state16), .RWDS(RWDS16), .DQ(DQ16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       drv;
        logic       v;
        logic [7:0] data;
        logic       rwds;
        logic       oe;
        logic [1:0] st;
        logic       de;
        logic       rdy;
        logic [7:0] dq;
        logic       rw;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle(input logic [7:0] d);
        tb_dq   = d;
        tb_rwds = ~tb_rwds;
    endtask

    int         q[$];
    logic       m_ovf;
    logic       popped;
    logic       do_t;
    logic       pend;
    logic [7:0] pend_d;
    int         presize;

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; rst16 = 1'b1;
        drv_req = 1'b0; tx_valid = 1'b0; tx_rwds = 1'b0; tx_rwds_oe = 1'b0;
        rx_en = 1'b0; rx_ready = 1'b0; ovf_clr = 1'b0;
        tx_data = 8'h00; tx_data16 = 16'h0000;
        tb_en = 1'b0; tb_rwds = 1'b0; tb_dq = 8'h00;
        step(); step();
        rst = 1'b0; rst16 = 1'b0;

        // Reset state
        check("rst_state",   {30'd0, bus_state}, 32'd0);
        check("rst_dq_de",   {31'd0, dut8.dq_de}, 32'd0);
        check("rst_rwds_de", {31'd0, dut8.rwds_de}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_ovf",     {31'd0, ovf}, 32'd0);

        // Direction / TX table: drv, v, data, rwds, oe | state, de, rdy, dq, rwds
        vq.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 8'h00, 1'b0});
        vq.push_back('{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 8'hA5, 1'b1});
        vq.push_back('{1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 8'h3C, 1'b0});
        vq.push_back('{1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 8'h3C, 1'b0});
        vq.push_back('{1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 8'h5A, 1'b1});
        vq.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 8'h5A, 1'b1});
        vq.push_back('{1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 8'hC3, 1'b1});
        vq.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0});
        vq.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0});

        foreach (vq[i]) begin
            drv_req = vq[i].drv; tx_valid = vq[i].v; tx_data = vq[i].data;
            tx_rwds = vq[i].rwds; tx_rwds_oe = vq[i].oe;
            step();
            check($sformatf("vec%0d_state", i), {30'd0, bus_state}, {30'd0, vq[i].st});
            check($sformatf("vec%0d_dq_de", i), {31'd0, dut8.dq_de}, {31'd0, vq[i].de});
            check($sformatf("vec%0d_rwds_de", i), {31'd0, dut8.rwds_de},
                  {31'd0, vq[i].de & vq[i].oe});
            check($sformatf("vec%0d_tx_ready", i), {31'd0, tx_ready}, {31'd0, vq[i].rdy});
            if (vq[i].de) begin
                check($sformatf("vec%0d_dq_pad", i), {24'd0, DQ8}, {24'd0, vq[i].dq});
                if (vq[i].oe) begin
                    check($sformatf("vec%0d_rwds_pad", i), {31'd0, RWDS8}, {31'd0, vq[i].rw});
                end
            end
        end
        tx_valid = 1'b0; drv_req = 1'b0;

        // Bench takes over the pads for receive; let synchronisers settle.
        tb_en = 1'b1; tb_rwds = 1'b0; tb_dq = 8'h00;
        repeat (6) step();
        check("rx_idle_empty", {31'd0, rx_valid}, 32'd0);

        // Nine edges with no pops: first eight kept, overflow flagged.
        rx_en = 1'b1; rx_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            toggle(8'(8'h10 + k));
            repeat (4) step();
        end
        repeat (4) step();
        check("ovf_after_9", {31'd0, ovf}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("pop%0d_valid", i), {31'd0, rx_valid}, 32'd1);
            check($sformatf("pop%0d_data", i), {24'd0, rx_data}, 32'(8'h10 + i));
            rx_ready = 1'b1; step(); rx_ready = 1'b0;
        end
        check("drained_valid", {31'd0, rx_valid}, 32'd0);
        check("drained_data", {24'd0, rx_data}, 32'd0);
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
        check("pop_empty_noeffect", {31'd0, rx_valid}, 32'd0);

        // Full FIFO: push and pop in the same cycle both succeed.
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, ovf}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            toggle(8'(8'h20 + k));
            repeat (4) step();
        end
        repeat (2) step();
        toggle(8'h28);
        repeat (3) step();
        rx_ready = 1'b1; step(); rx_ready = 1'b0;
        step();
        check("full_pushpop_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fp_pop%0d_data", i), {24'd0, rx_data}, 32'(8'h21 + i));
            rx_ready = 1'b1; step(); rx_ready = 1'b0;
        end
        check("fp_drained", {31'd0, rx_valid}, 32'd0);

        // Clear coinciding with an overflow wins; the next overflow sets again.
        for (int k = 0; k < 8; k++) begin
            toggle(8'(8'h30 + k));
            repeat (4) step();
        end
        repeat (2) step();
        toggle(8'h38);
        repeat (3) step();
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("ovf_clr_wins", {31'd0, ovf}, 32'd0);
        toggle(8'h39);
        repeat (4) step();
        check("ovf_sets_again", {31'd0, ovf}, 32'd1);
        check("ovf_head_kept", {24'd0, rx_data}, 32'h30);
        rx_ready = 1'b1; repeat (10) step(); rx_ready = 1'b0;
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        check("pre_random_empty", {31'd0, rx_valid}, 32'd0);

        // Randomized receive traffic against a queue model (push lands 4 edges after the pad edge).
        q.delete();
        m_ovf = 1'b0;
        for (int w = 0; w < 80; w++) begin
            do_t  = ($urandom_range(0, 1) == 1);
            rx_en = ($urandom_range(0, 3) != 0);
            pend  = do_t && rx_en;
            pend_d = 8'($urandom_range(0, 255));
            if (do_t) toggle(pend_d);
            for (int k = 1; k <= 4; k++) begin
                rx_ready = ($urandom_range(0, 2) == 0);
                ovf_clr  = ($urandom_range(0, 15) == 0);
                presize  = q.size();
                popped   = rx_ready && (presize > 0);
                step();
                if (popped) void'(q.pop_front());
                if (pend && k == 4) begin
                    if (presize < 8 || popped) q.push_back(int'(pend_d));
                    else if (!ovf_clr) m_ovf = 1'b1;
                end
                if (ovf_clr) m_ovf = 1'b0;
                check("rand_valid", {31'd0, rx_valid}, {31'd0, q.size() > 0});
                if (q.size() > 0) check("rand_data", {24'd0, rx_data}, 32'(q[0]));
                check("rand_ovf", {31'd0, ovf}, {31'd0, m_ovf});
            end
        end
        rx_ready = 1'b0; ovf_clr = 1'b0; rx_en = 1'b0;

        // Reset in the middle of a transmit burst.
        tb_en = 1'b0;
        drv_req = 1'b1;
        repeat (3) step();
        check("midtx_pre_de", {31'd0, dut8.dq_de}, 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        check("midtx_rst_de", {31'd0, dut8.dq_de}, 32'd0);
        check("midtx_rst_state", {30'd0, bus_state}, 32'd0);
        check("midtx_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        drv_req = 1'b0;
        step();

        // 16-bit instance: turnaround then a wide beat, then reset mid-TX.
        rst16 = 1'b1; step(); rst16 = 1'b0;
        check("w16_rst_state", {30'd0, bus_state16}, 32'd0);
        drv_req = 1'b1; tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("w16_turn%0d_state", i), {30'd0, bus_state16}, (i < 2) ? 32'd1 : 32'd2);
            check($sformatf("w16_turn%0d_de", i), {31'd0, dut16.dq_de}, (i < 2) ? 32'd0 : 32'd1);
        end
        tx_valid = 1'b1; tx_data16 = 16'hBEEF; tx_rwds = 1'b1; tx_rwds_oe = 1'b1;
        step();
        tx_valid = 1'b0;
        check("w16_dq_pad", {16'd0, DQ16}, 32'hBEEF);
        check("w16_rwds_pad", {31'd0, RWDS16}, 32'd1);
        rst16 = 1'b1; step(); rst16 = 1'b0;
        check("w16_rst_de", {31'd0, dut16.dq_de}, 32'd0);
        check("w16_rst_state2", {30'd0, bus_state16}, 32'd0);
        check("w16_rst_rx_valid", {31'd0, rx_valid16}, 32'd0);
        drv_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
